// File: rtl/watch_pkg.sv
// Shared field widths, default moduli and set-mode field encoding for the
// hours/minutes/seconds time counter.
package watch_pkg;

    // Output field widths
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Default moduli for a 24-hour clock
    localparam int SEC_MAX_DEF  = 60;
    localparam int MIN_MAX_DEF  = 60;
    localparam int HOUR_MAX_DEF = 24;

    // Field selected for editing while in set mode
    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2,
        SEL_NONE = 2'd3
    } set_sel_e;

    // True when the raw select code picks the given field and an increment is requested
    function automatic logic field_inc(input logic [1:0] sel, input set_sel_e field, input logic inc);
        return inc && (set_sel_e'(sel) == field);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Wrap-around counter 0..P_MAX-1.
// Two ways to advance: a carry from the lower stage (only while enabled), which
// also produces a registered one-cycle tick when the count wraps, and a direct
// increment (used by set mode), which wraps silently without a tick.
module mod_n_counter
    import watch_pkg::*;
#(
    parameter int P_WIDTH = 6,
    parameter int P_MAX   = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               carry_in,
    input  logic               inc,
    output logic [P_WIDTH-1:0] count,
    output logic               tick
);

    localparam logic [P_WIDTH-1:0] LAST = P_WIDTH'(P_MAX - 1);

    logic [P_WIDTH-1:0] count_reg, count_next;
    logic               tick_reg, tick_next;
    logic               at_last;
    logic               carry_adv;
    logic               advance;

    // Next-count and tick decode; anything at or past the last value wraps to 0
    always_comb begin
        at_last    = (count_reg >= LAST);
        carry_adv  = en & carry_in;
        advance    = carry_adv | inc;
        count_next = count_reg;
        if (advance) begin
            count_next = at_last ? '0 : count_reg + 1'b1;
        end
        tick_next  = carry_adv & at_last;
    end

    // State and tick registers, synchronous reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            tick_reg  <= tick_next;
        end
    end

    assign count = count_reg;
    assign tick  = tick_reg;

endmodule

// File: rtl/hms_time_counter.sv
// Hours/minutes/seconds time-of-day counter.
// Three cascaded wrap counters; set mode pauses the cascade and lets the user
// bump one field at a time without carrying into the others.
module hms_time_counter
    import watch_pkg::*;
#(
    parameter int P_SEC_MAX  = SEC_MAX_DEF,
    parameter int P_MIN_MAX  = MIN_MAX_DEF,
    parameter int P_HOUR_MAX = HOUR_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_one_sec_tick,
    input  logic              i_set_en,
    input  logic [1:0]        i_set_sel,
    input  logic              i_inc,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_min_tick,
    output logic              o_hour_tick,
    output logic              o_day_tick
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(P_SEC_MAX - 1);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(P_MIN_MAX - 1);

    logic count_en;
    logic sec_carry_in, min_carry_in, hour_carry_in;
    logic sec_inc, min_inc, hour_inc;

    // Set-mode gating and carry cascade: a stage advances only when every lower
    // stage is about to wrap on this same tick
    always_comb begin
        count_en      = ~i_set_en;
        sec_carry_in  = i_one_sec_tick;
        min_carry_in  = i_one_sec_tick & (o_sec >= SEC_LAST);
        hour_carry_in = min_carry_in & (o_min >= MIN_LAST);
        sec_inc       = i_set_en & field_inc(i_set_sel, SEL_SEC,  i_inc);
        min_inc       = i_set_en & field_inc(i_set_sel, SEL_MIN,  i_inc);
        hour_inc      = i_set_en & field_inc(i_set_sel, SEL_HOUR, i_inc);
    end

    mod_n_counter #(.P_WIDTH(SEC_W), .P_MAX(P_SEC_MAX)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .en       (count_en),
        .carry_in (sec_carry_in),
        .inc      (sec_inc),
        .count    (o_sec),
        .tick     (o_min_tick)
    );

    mod_n_counter #(.P_WIDTH(MIN_W), .P_MAX(P_MIN_MAX)) u_min (
        .clk      (clk),
        .reset    (reset),
        .en       (count_en),
        .carry_in (min_carry_in),
        .inc      (min_inc),
        .count    (o_min),
        .tick     (o_hour_tick)
    );

    mod_n_counter #(.P_WIDTH(HOUR_W), .P_MAX(P_HOUR_MAX)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .en       (count_en),
        .carry_in (hour_carry_in),
        .inc      (hour_inc),
        .count    (o_hour),
        .tick     (o_day_tick)
    );

endmodule

// File: tb/tb_hms_time_counter.sv
// Self-checking bench for hms_time_counter: directed scenarios followed by
// randomized stimulus, all compared against a time-of-day reference model.
module tb_hms_time_counter;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;
    localparam int DAY_SECS = SEC_MOD * MIN_MOD * HOUR_MOD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_one_sec_tick = 1'b0;
    logic       i_set_en = 1'b0;
    logic [1:0] i_set_sel = 2'd3;
    logic       i_inc = 1'b0;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_min_tick, o_hour_tick, o_day_tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_s = 0, m_m = 0, m_h = 0;
    int m_mt = 0, m_ht = 0, m_dt = 0;

    hms_time_counter dut (
        .clk            (clk),
        .reset          (reset),
        .i_one_sec_tick (i_one_sec_tick),
        .i_set_en       (i_set_en),
        .i_set_sel      (i_set_sel),
        .i_inc          (i_inc),
        .o_sec          (o_sec),
        .o_min          (o_min),
        .o_hour         (o_hour),
        .o_min_tick     (o_min_tick),
        .o_hour_tick    (o_hour_tick),
        .o_day_tick     (o_day_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance the reference model by one clock edge with the given inputs
    task automatic model_update(input bit r, input bit t, input bit se, input logic [1:0] s, input bit i);
        int total;
        if (r) begin
            m_s = 0; m_m = 0; m_h = 0;
            m_mt = 0; m_ht = 0; m_dt = 0;
        end else if (!se) begin
            m_mt = 0; m_ht = 0; m_dt = 0;
            if (t) begin
                total = ((m_h * MIN_MOD + m_m) * SEC_MOD + m_s + 1) % DAY_SECS;
                m_s = total % SEC_MOD;
                m_m = (total / SEC_MOD) % MIN_MOD;
                m_h = total / (SEC_MOD * MIN_MOD);
                m_mt = (m_s == 0) ? 1 : 0;
                m_ht = (m_mt == 1 && m_m == 0) ? 1 : 0;
                m_dt = (m_ht == 1 && m_h == 0) ? 1 : 0;
            end
        end else begin
            m_mt = 0; m_ht = 0; m_dt = 0;
            if (i) begin
                case (s)
                    2'd0: m_s = (m_s + 1) % SEC_MOD;
                    2'd1: m_m = (m_m + 1) % MIN_MOD;
                    2'd2: m_h = (m_h + 1) % HOUR_MOD;
                    default: ;
                endcase
            end
        end
    endtask

    // One clock cycle: drive inputs, clock, then compare every output to the model
    task automatic step(input string tag, input bit r, input bit t, input bit se,
                        input logic [1:0] s, input bit i);
        reset = r;
        i_one_sec_tick = t;
        i_set_en = se;
        i_set_sel = s;
        i_inc = i;
        @(posedge clk);
        model_update(r, t, se, s, i);
        #1;
        check({tag, ".sec"},       32'(o_sec),       32'(m_s));
        check({tag, ".min"},       32'(o_min),       32'(m_m));
        check({tag, ".hour"},      32'(o_hour),      32'(m_h));
        check({tag, ".min_tick"},  32'(o_min_tick),  32'(m_mt));
        check({tag, ".hour_tick"}, 32'(o_hour_tick), 32'(m_ht));
        check({tag, ".day_tick"},  32'(o_day_tick),  32'(m_dt));
    endtask

    // Bring the counter to h:m:s through reset and set-mode increments
    task automatic load(input int h, input int m, input int s);
        step("load_rst", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        for (int k = 0; k < s; k++) step("load_sec",  1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        for (int k = 0; k < m; k++) step("load_min",  1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        for (int k = 0; k < h; k++) step("load_hour", 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);
        step("load_run", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        $display("[TB] loaded %0d:%0d:%0d", h, m, s);
    endtask

    initial begin
        bit se_mode;

        // Power-on reset
        step("por", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        $display("[TB] power-on reset");

        // Reset from 12:34:56
        load(12, 34, 56);
        check("pre_rst_hour", 32'(o_hour), 32'd12);
        step("reset", 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        check("reset_sec", 32'(o_sec), 32'd0);
        check("reset_hour", 32'(o_hour), 32'd0);
        $display("[TB] reset from 12:34:56");

        // Seconds wrap from 00:00:59
        load(0, 0, 59);
        step("sec_wrap", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
        check("sec_wrap_min", 32'(o_min), 32'd1);
        check("sec_wrap_mtick", 32'(o_min_tick), 32'd1);
        step("sec_wrap_after", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        check("sec_wrap_mtick_drop", 32'(o_min_tick), 32'd0);
        $display("[TB] seconds wrap 00:00:59 -> 00:01:00");

        // Full cascade from 23:59:59
        load(23, 59, 59);
        step("cascade", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
        check("cascade_hour", 32'(o_hour), 32'd0);
        check("cascade_day_tick", 32'(o_day_tick), 32'd1);
        step("cascade_after", 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        check("cascade_day_tick_drop", 32'(o_day_tick), 32'd0);
        $display("[TB] full cascade 23:59:59 -> 00:00:00");

        // Set mode: minutes 58 -> 01 with concurrent seconds ticks ignored
        load(5, 58, 7);
        for (int k = 0; k < 3; k++) step("set_min", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
        check("set_min_val", 32'(o_min), 32'd1);
        check("set_min_hour", 32'(o_hour), 32'd5);
        check("set_min_sec", 32'(o_sec), 32'd7);
        step("set_exit", 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
        check("set_resume_sec", 32'(o_sec), 32'd8);
        $display("[TB] set mode minutes 58 -> 01");

        // Input gating: inc ignored while counting; sel=3 inc is a no-op
        load(0, 0, 10);
        step("gate_inc_tick", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        check("gate_sec", 32'(o_sec), 32'd11);
        step("gate_sel3", 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
        check("gate_sel3_sec", 32'(o_sec), 32'd11);
        $display("[TB] input gating at 00:00:10");

        // Reset priority over a full cascade
        load(23, 59, 59);
        step("rst_prio", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
        check("rst_prio_mtick", 32'(o_min_tick), 32'd0);
        check("rst_prio_dtick", 32'(o_day_tick), 32'd0);
        $display("[TB] reset priority at 23:59:59");

        // Randomized stimulus
        se_mode = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            bit r, t, i;
            logic [1:0] s;
            if ($urandom_range(0, 39) == 0) se_mode = ~se_mode;
            r = ($urandom_range(0, 499) == 0);
            t = ($urandom_range(0, 1) == 0);
            i = ($urandom_range(0, 1) == 0);
            s = 2'($urandom_range(0, 3));
            step("rand", r, t, se_mode, s, i);
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hms_time_counter.md
HMS_TIME_COUNTER -- requirements
Module: hms_time_counter

Interface
REQ-001 SHALL have parameter P_SEC_MAX, default 60, seconds modulus.
REQ-002 SHALL have parameter P_MIN_MAX, default 60, minutes modulus.
REQ-003 SHALL have parameter P_HOUR_MAX, default 24, hours modulus.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_one_sec_tick  input  1  one-cycle pulse from the upstream 1 s tick generator.
REQ-007 SHALL have port i_set_en  input  1  level; high = set mode, counting paused.
REQ-008 SHALL have port i_set_sel  input  2  field select: 0 sec, 1 min, 2 hour, 3 none.
REQ-009 SHALL have port i_inc  input  1  one-cycle pulse; increments the selected field in set mode.
REQ-010 SHALL have port o_sec  output  6  current seconds, 0..P_SEC_MAX-1.
REQ-011 SHALL have port o_min  output  6  current minutes, 0..P_MIN_MAX-1.
REQ-012 SHALL have port o_hour  output  5  current hours, 0..P_HOUR_MAX-1.
REQ-013 SHALL have port o_min_tick  output  1  one-cycle pulse on seconds wrap.
REQ-014 SHALL have port o_hour_tick  output  1  one-cycle pulse on minutes wrap.
REQ-015 SHALL have port o_day_tick  output  1  one-cycle pulse on hours wrap.

Function
REQ-016 SHALL drive all outputs from registers; no combinational path from input to output.
REQ-017 SHALL, with i_set_en low and i_one_sec_tick high, increment o_sec on the next clock edge (latency 1 cycle).
REQ-018 SHALL wrap o_sec from P_SEC_MAX-1 to 0 and increment o_min in the same cycle.
REQ-019 SHALL wrap o_min from P_MIN_MAX-1 to 0 only when o_sec also wraps, incrementing o_hour in the same cycle.
REQ-020 SHALL wrap o_hour from P_HOUR_MAX-1 to 0 only when o_sec and o_min also wrap.
REQ-021 SHALL assert each carry tick for exactly the cycle in which its wrapped (zero) value first appears on the outputs; otherwise 0.
REQ-022 SHALL, with i_set_en high, ignore i_one_sec_tick; held values do not advance and no carry ticks are emitted.
REQ-023 SHALL, with i_set_en high and i_inc high, increment only the selected field by 1 with modulo wrap and no carry to higher fields; no tick outputs asserted.
REQ-024 SHALL treat i_set_sel=3 with i_inc as no operation.
REQ-025 SHALL ignore i_inc while i_set_en is low, including when it coincides with i_one_sec_tick.
REQ-026 SHALL resume counting from the held or edited values on the first tick after i_set_en falls; no catch-up for ticks missed in set mode.
REQ-027 SHALL keep every field within range at all times; arithmetic is unsigned, and values at or above the modulus are unreachable.

Reset
REQ-028 SHALL, when reset is high at a clock edge, set o_sec, o_min, o_hour, o_min_tick, o_hour_tick and o_day_tick to 0 on that edge.
REQ-029 SHALL give reset priority over tick, set and inc inputs, including mid-cascade at 23:59:59.
REQ-030 SHALL resume normal operation on the first edge after reset deasserts.

Structure
REQ-031 SHALL take field widths (6, 6, 5) and default moduli (60, 60, 24) from shared package watch_pkg.
REQ-032 SHALL be built from three instances of sub-module mod_n_counter, a parameterised wrap counter with enable, increment, carry-in and registered carry-out tick.
REQ-033 SHALL contain only the set-mode gating and cascade wiring at top level.

Verification
REQ-034 SHALL verify reset: state 12:34:56, assert reset for 1 cycle -> next edge all outputs 0, ticks 0.
REQ-035 SHALL verify seconds wrap: from 00:00:59, one tick -> 00:01:00 after 1 cycle, o_min_tick=1 for that one cycle only.
REQ-036 SHALL verify full cascade: from 23:59:59, one tick -> 00:00:00, with o_min_tick, o_hour_tick and o_day_tick all 1 in the same single cycle.
REQ-037 SHALL verify set mode: i_set_en=1, sel=1, 3 inc pulses from min 58 -> min 01, hour unchanged, no ticks; concurrent i_one_sec_tick pulses leave o_sec unchanged.
REQ-038 SHALL verify input gating: i_set_en=0, i_inc coincident with tick at 00:00:10 -> 00:00:11 only; sel=3 with inc in set mode -> no change.
REQ-039 SHALL verify reset priority: reset and tick in the same cycle at 23:59:59 -> 00:00:00 with all ticks 0.
